// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the integer register file and its dump engine.
// No logic; imported by every file of the block.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } dump_state_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Read/write/issue/debug-dump signal bundle between the core and the register file.
// slave = register file side, master = core/debug side.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NREAD-1:0][AW-1:0]   ra;
  logic [NREAD-1:0][XLEN-1:0] rd;
  logic [NREAD-1:0]           rd_busy;
  logic                       we;
  logic [AW-1:0]              wa;
  logic [XLEN-1:0]            wd;
  logic                       iss_valid;
  logic [AW-1:0]              iss_rd;
  logic                       dbg_req;
  logic                       dbg_valid;
  logic                       dbg_ready;
  logic [AW-1:0]              dbg_idx;
  logic [XLEN-1:0]            dbg_data;
  logic                       dbg_done;

  modport slave (
    input  ra, we, wa, wd, iss_valid, iss_rd, dbg_req, dbg_ready,
    output rd, rd_busy, dbg_valid, dbg_idx, dbg_data, dbg_done
  );

  modport master (
    output ra, we, wa, wd, iss_valid, iss_rd, dbg_req, dbg_ready,
    input  rd, rd_busy, dbg_valid, dbg_idx, dbg_data, dbg_done
  );

endinterface

// File: rtl/regfile_dump.sv
// Debug dump engine: streams registers 0..NREGS-1 as valid/ready beats, one per accepted cycle.
// Beat data is captured on load and held while dbg_ready is low; dbg_done pulses after the last beat.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dbg_req,
  input  logic            dbg_ready,
  output logic            dbg_valid,
  output logic [AW-1:0]   dbg_idx,
  output logic [XLEN-1:0] dbg_data,
  output logic            dbg_done,
  output logic [AW-1:0]   rd_idx,
  input  logic [XLEN-1:0] rd_data
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  dump_state_e     state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            done_q, done_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    done_d    = 1'b0;
    rd_idx    = '0;
    dbg_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (dbg_req) begin
          state_d = DUMP;
          idx_d   = '0;
          data_d  = rd_data;
        end
      end
      DUMP: begin
        dbg_valid = 1'b1;
        // Look ahead one register so the next beat loads on the accepting edge.
        if (idx_q != LAST_IDX) rd_idx = AW'(idx_q + 1'b1);
        if (dbg_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d  = AW'(idx_q + 1'b1);
            data_d = rd_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign dbg_idx  = idx_q;
  assign dbg_data = data_q;
  assign dbg_done = done_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: NREAD combinational read ports with write bypass, x0 = 0, pending-write scoreboard.
// Reads are 0-latency; the debug dump never stalls reads, writes or the scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NREAD = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             wr_en;
  logic [AW-1:0]    dump_idx;
  logic [XLEN-1:0]  dump_dat;

  assign wr_en = bus.we && (bus.wa != '0);

  always_comb begin
    bus.rd      = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (bus.ra[i] == '0)
        bus.rd[i] = '0;
      else if (wr_en && (bus.wa == bus.ra[i]))
        bus.rd[i] = bus.wd;
      else
        bus.rd[i] = regs_q[bus.ra[i]];
      // A writeback landing this cycle already resolves the hazard.
      bus.rd_busy[i] = busy_q[bus.ra[i]] & ~(bus.we && (bus.wa == bus.ra[i]));
    end
  end

  always_comb begin
    dump_dat = '0;
    if (dump_idx == '0)
      dump_dat = '0;
    else if (wr_en && (bus.wa == dump_idx))
      dump_dat = bus.wd;
    else
      dump_dat = regs_q[dump_idx];
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[bus.wa] = bus.wd;
  end

  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[bus.wa] = 1'b0;
    // A fresh issue to the same index outranks the older producer's writeback.
    if (bus.iss_valid && (bus.iss_rd != '0)) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  regfile_dump #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_dump (
    .clk       (clk),
    .rst       (rst),
    .dbg_req   (bus.dbg_req),
    .dbg_ready (bus.dbg_ready),
    .dbg_valid (bus.dbg_valid),
    .dbg_idx   (bus.dbg_idx),
    .dbg_data  (bus.dbg_data),
    .dbg_done  (bus.dbg_done),
    .rd_idx    (dump_idx),
    .rd_data   (dump_dat)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic against an array model.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] mregs [NREGS];
  bit              mbusy [NREGS];

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.we && bus.wa == a) return bus.wd;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return mbusy[a] && !(bus.we && bus.wa == a);
  endfunction

  task automatic drive_idle();
    bus.ra        = '0;
    bus.we        = 1'b0;
    bus.wa        = '0;
    bus.wd        = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.dbg_req   = 1'b0;
    bus.dbg_ready = 1'b0;
  endtask

  // Advance one clock; the model follows the architectural rules at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        mregs[k] = '0;
        mbusy[k] = 1'b0;
      end
    end else begin
      if (bus.we && bus.wa != 0) begin
        mregs[bus.wa] = bus.wd;
        mbusy[bus.wa] = 1'b0;
      end
      if (bus.iss_valid && bus.iss_rd != 0) mbusy[bus.iss_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    for (int k = 0; k < NREGS; k++) begin
      mregs[k] = '0;
      mbusy[k] = 1'b0;
    end
    @(negedge clk);
    bus.ra[0] = 5'd3;
    bus.ra[1] = 5'd31;
    #1;
    total++; if (bus.rd !== '0) begin bad++; $display("FAIL reset_rd: got %h want 0", bus.rd); end
    total++; if (bus.rd_busy !== '0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.rd_busy); end
    total++; if ({bus.dbg_valid, bus.dbg_done} !== 2'b00) begin bad++; $display("FAIL reset_dbg_flags: got %b want 00", {bus.dbg_valid, bus.dbg_done}); end
    total++; if (bus.dbg_idx !== '0 || bus.dbg_data !== '0) begin bad++; $display("FAIL reset_dbg_beat: got idx=%0d data=%h want 0/0", bus.dbg_idx, bus.dbg_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    drive_idle();
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEADBEEF;
    tick();
    bus.we = 1'b0; bus.ra[0] = 5'd5;
    #1;
    total++; if (bus.rd[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_x5: got %h want deadbeef", bus.rd[0]); end
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'h1234; bus.ra[0] = 5'd0; bus.ra[1] = 5'd0;
    #1;
    total++; if (bus.rd[0] !== '0) begin bad++; $display("FAIL wr_x0_bypass: got %h want 0", bus.rd[0]); end
    tick();
    bus.we = 1'b0;
    #1;
    total++; if (bus.rd[1] !== '0) begin bad++; $display("FAIL wr_x0_stored: got %h want 0", bus.rd[1]); end
    tick();
  endtask

  task automatic test_bypass();
    drive_idle();
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'hA5A5A5A5; bus.ra[1] = 5'd7; bus.ra[0] = 5'd5;
    #1;
    total++; if (bus.rd[1] !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass_same_cycle: got %h want a5a5a5a5", bus.rd[1]); end
    total++; if (bus.rd[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_other_port: got %h want deadbeef", bus.rd[0]); end
    tick();
    bus.we = 1'b0;
    #1;
    total++; if (bus.rd[1] !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass_stored: got %h want a5a5a5a5", bus.rd[1]); end
    tick();
  endtask

  task automatic test_scoreboard();
    drive_idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3; bus.ra[0] = 5'd3; bus.ra[1] = 5'd0;
    tick();
    bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
    #1;
    total++; if (bus.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_issue: got %b want 1", bus.rd_busy[0]); end
    total++; if (bus.rd_busy[1] !== 1'b0) begin bad++; $display("FAIL sb_x0: got %b want 0", bus.rd_busy[1]); end
    bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h33; bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    tick();
    bus.we = 1'b0; bus.iss_valid = 1'b0;
    #1;
    total++; if (bus.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_set_wins: got %b want 1", bus.rd_busy[0]); end
    bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h34;
    #1;
    total++; if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_wb_comb: got %b want 0", bus.rd_busy[0]); end
    tick();
    bus.we = 1'b0;
    #1;
    total++; if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_wb_cleared: got %b want 0", bus.rd_busy[0]); end
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    tick();
    bus.iss_valid = 1'b0; bus.ra[0] = 5'd0;
    #1;
    total++; if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_issue_x0: got %b want 0", bus.rd_busy[0]); end
    tick();
  endtask

  task automatic test_random();
    drive_idle();
    for (int c = 0; c < 400; c++) begin
      bus.we        = 1'($urandom_range(0, 1));
      bus.wa        = AW'($urandom_range(0, (c % 2) ? 31 : 7));
      bus.wd        = $urandom;
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd    = AW'($urandom_range(0, 7));
      for (int p = 0; p < NREAD; p++) bus.ra[p] = AW'($urandom_range(0, (c % 3) ? 7 : 31));
      #1;
      for (int p = 0; p < NREAD; p++) begin
        total++;
        if (bus.rd[p] !== exp_rd(bus.ra[p])) begin
          bad++; $display("FAIL rand_rd[%0d] cyc %0d ra=%0d: got %h want %h", p, c, bus.ra[p], bus.rd[p], exp_rd(bus.ra[p]));
        end
        total++;
        if (bus.rd_busy[p] !== exp_busy(bus.ra[p])) begin
          bad++; $display("FAIL rand_busy[%0d] cyc %0d ra=%0d: got %b want %b", p, c, bus.ra[p], bus.rd_busy[p], exp_busy(bus.ra[p]));
        end
      end
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_dump_full();
    drive_idle();
    for (int i = 1; i < NREGS; i++) begin
      bus.we = 1'b1; bus.wa = AW'(i); bus.wd = XLEN'(i);
      tick();
    end
    bus.we = 1'b0;
    bus.dbg_req = 1'b1;
    tick();
    bus.dbg_ready = 1'b1;
    for (int k = 0; k < NREGS; k++) begin
      bus.dbg_req = (k == 5);
      #1;
      total++;
      if (bus.dbg_valid !== 1'b1 || bus.dbg_idx !== AW'(k) || bus.dbg_data !== mregs[k] || bus.dbg_done !== 1'b0) begin
        bad++; $display("FAIL dump_beat %0d: got v=%b idx=%0d data=%h done=%b want 1/%0d/%h/0",
                        k, bus.dbg_valid, bus.dbg_idx, bus.dbg_data, bus.dbg_done, k, mregs[k]);
      end
      tick();
    end
    bus.dbg_req = 1'b0;
    #1;
    total++; if (bus.dbg_done !== 1'b1 || bus.dbg_valid !== 1'b0) begin bad++; $display("FAIL dump_done: got done=%b v=%b want 1/0", bus.dbg_done, bus.dbg_valid); end
    tick();
    #1;
    total++; if (bus.dbg_done !== 1'b0 || bus.dbg_valid !== 1'b0) begin bad++; $display("FAIL dump_done_pulse: got done=%b v=%b want 0/0", bus.dbg_done, bus.dbg_valid); end
    tick();
  endtask

  task automatic test_dump_stall();
    logic [XLEN-1:0] snap [NREGS];
    int beat;
    int cyc;
    bit rdy;
    drive_idle();
    for (int i = 1; i < NREGS; i++) begin
      bus.we = 1'b1; bus.wa = AW'(i); bus.wd = $urandom;
      tick();
    end
    bus.we = 1'b0;
    for (int k = 0; k < NREGS; k++) snap[k] = mregs[k];
    bus.dbg_req = 1'b1;
    tick();
    bus.dbg_req = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat < NREGS && cyc < 600) begin
      rdy = (cyc % 2 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.dbg_ready = rdy;
      // Overwrite the register whose beat is currently held.
      bus.we = !rdy; bus.wa = AW'(beat); bus.wd = $urandom;
      #1;
      total++;
      if (bus.dbg_valid !== 1'b1 || bus.dbg_idx !== AW'(beat) || bus.dbg_data !== snap[beat]) begin
        bad++; $display("FAIL stall_beat %0d cyc %0d: got v=%b idx=%0d data=%h want 1/%0d/%h",
                        beat, cyc, bus.dbg_valid, bus.dbg_idx, bus.dbg_data, beat, snap[beat]);
      end
      tick();
      if (rdy) beat++;
      cyc++;
    end
    total++; if (beat != NREGS) begin bad++; $display("FAIL stall_timeout: got %0d beats want %0d", beat, NREGS); end
    bus.we = 1'b0; bus.dbg_ready = 1'b0;
    #1;
    total++; if (bus.dbg_done !== 1'b1 || bus.dbg_valid !== 1'b0) begin bad++; $display("FAIL stall_done: got done=%b v=%b want 1/0", bus.dbg_done, bus.dbg_valid); end
    tick();
  endtask

  task automatic test_reset_mid_dump();
    bit seen_done;
    drive_idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    tick();
    bus.iss_valid = 1'b0;
    bus.dbg_req = 1'b1;
    tick();
    bus.dbg_req = 1'b0; bus.dbg_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    #1;
    total++; if (bus.dbg_valid !== 1'b1 || bus.dbg_idx !== 5'd10) begin bad++; $display("FAIL rstd_pre: got v=%b idx=%0d want 1/10", bus.dbg_valid, bus.dbg_idx); end
    rst = 1'b1;
    #1;
    total++; if (bus.dbg_valid !== 1'b0 || bus.dbg_done !== 1'b0 || bus.dbg_idx !== '0) begin bad++; $display("FAIL rstd_async: got v=%b done=%b idx=%0d want 0/0/0", bus.dbg_valid, bus.dbg_done, bus.dbg_idx); end
    tick();
    rst = 1'b0;
    bus.dbg_ready = 1'b0;
    for (int j = 0; j < NREGS / 2; j++) begin
      bus.ra[0] = AW'(2 * j); bus.ra[1] = AW'(2 * j + 1);
      #1;
      total++;
      if (bus.rd !== '0 || bus.rd_busy !== '0 || bus.rd[0] !== exp_rd(bus.ra[0])) begin
        bad++; $display("FAIL rstd_regs x%0d/x%0d: got rd=%h busy=%b want 0/0", 2 * j, 2 * j + 1, bus.rd, bus.rd_busy);
      end
      total++; if (bus.dbg_done !== 1'b0 || bus.dbg_valid !== 1'b0) begin bad++; $display("FAIL rstd_idle %0d: got done=%b v=%b want 0/0", j, bus.dbg_done, bus.dbg_valid); end
      tick();
    end
    bus.dbg_req = 1'b1;
    tick();
    bus.dbg_req = 1'b0;
    #1;
    total++; if (bus.dbg_valid !== 1'b1 || bus.dbg_idx !== '0 || bus.dbg_data !== '0) begin bad++; $display("FAIL rstd_restart: got v=%b idx=%0d data=%h want 1/0/0", bus.dbg_valid, bus.dbg_idx, bus.dbg_data); end
    bus.dbg_ready = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      tick();
      #1;
      if (bus.dbg_done) seen_done = 1'b1;
    end
    total++; if (seen_done !== 1'b1) begin bad++; $display("FAIL rstd_finish: got done=%b want 1", seen_done); end
    drive_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_random();
    test_dump_full();
    test_dump_stall();
    test_reset_mid_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
